// File: rtl/spi_tx_pkg.sv
// Shared types and lane helpers for the multi-lane SPI transmit shifter.
package spi_tx_pkg;

   typedef enum logic [1:0] {
      SPI_SINGLE = 2'b00,
      SPI_DUAL   = 2'b01,
      SPI_QUAD   = 2'b10
   } lane_mode_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      TRANSMIT = 2'b01,
      STALL    = 2'b10
   } state_e;

   // Reserved encoding 2'b11 behaves as single lane.
   function automatic logic [2:0] lanes(input logic [1:0] mode);
      case (mode)
         2'b01:   return 3'd2;
         2'b10:   return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic [1:0] lanes_log2(input logic [1:0] mode);
      case (mode)
         2'b01:   return 2'd1;
         2'b10:   return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/spi_tx_lane_sel.sv
// Maps the shift register onto the SDO lanes and drives per-lane output enables.
module spi_tx_lane_sel
   import spi_tx_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MAX_LANES = 4
) (
   input  logic [DATA_W-1:0]    i_shreg,
   input  logic [2:0]           i_lanes,
   input  logic                 i_lsb_first,
   input  logic                 i_active,
   output logic [MAX_LANES-1:0] o_sdo,
   output logic [MAX_LANES-1:0] o_sdo_oe
);

   localparam int IW = $clog2(DATA_W);

   logic [IW-1:0] w_base;

   // MSB-first lanes read the top L bits of the register.
   assign w_base = IW'(DATA_W - int'(i_lanes));

   for (genvar k = 0; k < MAX_LANES; k++) begin : g_lane
      logic w_use;
      assign w_use       = (3'(k) < i_lanes);
      assign o_sdo[k]    = w_use & (i_lsb_first ? i_shreg[k] : i_shreg[w_base + IW'(k)]);
      assign o_sdo_oe[k] = w_use & i_active;
   end

endmodule

// File: rtl/spi_master_tx_mw.sv
// SPI master transmit shifter: 1/2/4 lanes, MSB/LSB first, underrun stall and abort.
module spi_master_tx_mw
   import spi_tx_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 16,
   parameter int MAX_LANES = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en,
   input  logic                 tx_edge,
   input  logic [1:0]           mode_in,
   input  logic                 lsb_first_in,
   input  logic [CNT_W-1:0]     counter_in,
   input  logic                 counter_in_upd,
   input  logic [DATA_W-1:0]    data,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic [MAX_LANES-1:0] sdo,
   output logic [MAX_LANES-1:0] sdo_oe,
   output logic                 clk_en_o,
   output logic                 tx_done,
   output logic                 underrun
);

   localparam int WP_W = $clog2(DATA_W + 1);

   state_e            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, r_tgt;
   logic [WP_W-1:0]   r_wpos, w_wpos_nxt;
   logic [DATA_W-1:0] r_shreg, w_shreg_nxt, w_shifted;
   lane_mode_e        r_mode, w_mode_lat;
   logic              r_lsb;
   logic [CNT_W:0]    w_tgt_sum;
   logic [CNT_W-1:0]  w_tgt_lat;
   logic [2:0]        w_lanes;
   logic [WP_W-1:0]   w_wpw;
   logic              w_final, w_last;

   // Config latch: clamp modes wider than the lane count, round length up to whole shifts.
   always_comb begin
      w_mode_lat = (mode_in == 2'b01 || mode_in == 2'b10) ? lane_mode_e'(mode_in) : SPI_SINGLE;
      if (int'(lanes(w_mode_lat)) > MAX_LANES) w_mode_lat = SPI_SINGLE;
      w_tgt_sum = {1'b0, counter_in} + (CNT_W+1)'(lanes(w_mode_lat)) - 1'b1;
      w_tgt_lat = CNT_W'(w_tgt_sum >> lanes_log2(w_mode_lat));
      if (w_tgt_lat == '0) w_tgt_lat = CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mode <= SPI_SINGLE;
         r_lsb  <= 1'b0;
         r_tgt  <= CNT_W'(DATA_W);
      end else if (r_state == IDLE && counter_in_upd) begin
         r_mode <= w_mode_lat;
         r_lsb  <= lsb_first_in;
         r_tgt  <= w_tgt_lat;
      end
   end

   // r_wpos tracks counter mod (DATA_W / L) so no divider is needed.
   assign w_lanes   = lanes(r_mode);
   assign w_wpw     = WP_W'(DATA_W >> lanes_log2(r_mode));
   assign w_last    = (r_wpos == w_wpw - 1'b1);
   assign w_final   = (r_cnt == r_tgt - 1'b1);
   assign w_shifted = r_lsb ? (r_shreg >> w_lanes) : (r_shreg << w_lanes);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_wpos  <= '0;
         r_shreg <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wpos  <= w_wpos_nxt;
         r_shreg <= w_shreg_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wpos_nxt  = r_wpos;
      w_shreg_nxt = r_shreg;
      data_ready  = 1'b0;
      clk_en_o    = 1'b0;
      tx_done     = 1'b0;
      underrun    = 1'b0;
      case (r_state)
         IDLE: begin
            if (rstn && en && data_valid) begin
               data_ready  = 1'b1;
               w_shreg_nxt = data;
               w_cnt_nxt   = '0;
               w_wpos_nxt  = '0;
               w_state_nxt = TRANSMIT;
            end
         end
         TRANSMIT: begin
            clk_en_o = 1'b1;
            if (!en) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_wpos_nxt  = '0;
            end else if (tx_edge) begin
               w_shreg_nxt = w_shifted;
               w_cnt_nxt   = r_cnt + 1'b1;
               w_wpos_nxt  = w_last ? '0 : r_wpos + 1'b1;
               if (w_final) begin
                  tx_done    = 1'b1;
                  w_cnt_nxt  = '0;
                  w_wpos_nxt = '0;
                  if (data_valid) begin
                     data_ready  = 1'b1;
                     w_shreg_nxt = data;
                  end else begin
                     clk_en_o    = 1'b0;
                     w_state_nxt = IDLE;
                  end
               end else if (w_last) begin
                  if (data_valid) begin
                     data_ready  = 1'b1;
                     w_shreg_nxt = data;
                  end else begin
                     clk_en_o    = 1'b0;
                     underrun    = 1'b1;
                     w_state_nxt = STALL;
                  end
               end
            end
         end
         STALL: begin
            if (!en) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_wpos_nxt  = '0;
            end else if (data_valid) begin
               data_ready  = 1'b1;
               w_shreg_nxt = data;
               w_state_nxt = TRANSMIT;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   spi_tx_lane_sel #(
      .DATA_W    (DATA_W),
      .MAX_LANES (MAX_LANES)
   ) u_lane_sel (
      .i_shreg     (r_shreg),
      .i_lanes     (w_lanes),
      .i_lsb_first (r_lsb),
      .i_active    (r_state != IDLE),
      .o_sdo       (sdo),
      .o_sdo_oe    (sdo_oe)
   );

endmodule

// File: tb/tb_spi_master_tx_mw.sv
// Randomised bench for spi_master_tx_mw against a word/offset reference model.
module tb_spi_master_tx_mw;

   localparam int DW = 32;
   localparam int CW = 16;
   localparam int ML = 4;

   logic          clk = 1'b0, rstn = 1'b0, en = 1'b0, tx_edge = 1'b0;
   logic [1:0]    mode_in = 2'b00;
   logic          lsb_first_in = 1'b0, counter_in_upd = 1'b0, data_valid = 1'b0;
   logic [CW-1:0] counter_in = '0;
   logic [DW-1:0] data = '0;
   logic          data_ready, clk_en_o, tx_done, underrun;
   logic [ML-1:0] sdo, sdo_oe;

   spi_master_tx_mw #(.DATA_W(DW), .CNT_W(CW), .MAX_LANES(ML)) dut (
      .clk(clk), .rstn(rstn), .en(en), .tx_edge(tx_edge), .mode_in(mode_in),
      .lsb_first_in(lsb_first_in), .counter_in(counter_in), .counter_in_upd(counter_in_upd),
      .data(data), .data_valid(data_valid), .data_ready(data_ready), .sdo(sdo),
      .sdo_oe(sdo_oe), .clk_en_o(clk_en_o), .tx_done(tx_done), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // {ready, sdo[3:0], oe[3:0], clk_en, done, underrun}
   wire [11:0] dut_v = {data_ready, sdo, sdo_oe, clk_en_o, tx_done, underrun};

   int checks = 0;
   int errors = 0;
   logic [11:0] act_v, exp_v;

   // Model: state 0 idle, 1 transmit, 2 stall; word plus bits shifted out so far.
   int          m_st, m_cnt, m_tgt, m_L, m_sh;
   int          n_st, n_cnt, n_tgt, n_L, n_sh;
   bit          m_lsb, m_dir, n_lsb, n_dir;
   logic [31:0] m_word, n_word;

   function automatic int mlanes(input logic [1:0] m);
      int l;
      l = (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
      if (l > ML) l = 1;
      return l;
   endfunction

   function automatic int exp_target(input int cin, input int l);
      int t;
      t = (cin + l - 1) / l;
      return (t == 0) ? 1 : t;
   endfunction

   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_tgt = 32; m_L = 1; m_lsb = 0; m_dir = 0; m_word = '0; m_sh = 0;
   endtask

   task automatic model_eval();
      logic [31:0] v;
      logic [3:0]  e_sdo, e_oe;
      logic        e_rdy, e_clk, e_done, e_und;
      n_st = m_st; n_cnt = m_cnt; n_tgt = m_tgt; n_L = m_L; n_sh = m_sh;
      n_lsb = m_lsb; n_dir = m_dir; n_word = m_word;
      e_rdy = 0; e_clk = 0; e_done = 0; e_und = 0; e_sdo = '0; e_oe = '0;
      v = m_dir ? (m_word >> m_sh) : (m_word << m_sh);
      for (int k = 0; k < m_L; k++) begin
         e_sdo[k] = m_lsb ? v[k] : v[32 - m_L + k];
         e_oe[k]  = (m_st != 0);
      end
      case (m_st)
         0: begin
            if (counter_in_upd) begin
               n_L = mlanes(mode_in); n_lsb = lsb_first_in;
               n_tgt = exp_target(int'(counter_in), n_L);
            end
            if (en && data_valid) begin
               e_rdy = 1; n_word = data; n_sh = 0; n_dir = n_lsb; n_cnt = 0; n_st = 1;
            end
         end
         1: begin
            e_clk = 1;
            if (!en) begin
               n_st = 0; n_cnt = 0;
            end else if (tx_edge) begin
               n_sh = m_sh + m_L;
               if (m_cnt == m_tgt - 1) begin
                  e_done = 1; n_cnt = 0;
                  if (data_valid) begin e_rdy = 1; n_word = data; n_sh = 0; n_dir = m_lsb; end
                  else begin e_clk = 0; n_st = 0; end
               end else begin
                  n_cnt = m_cnt + 1;
                  if ((m_cnt + 1) % (32 / m_L) == 0) begin
                     if (data_valid) begin e_rdy = 1; n_word = data; n_sh = 0; n_dir = m_lsb; end
                     else begin e_clk = 0; e_und = 1; n_st = 2; end
                  end
               end
            end
         end
         default: begin
            if (!en) begin
               n_st = 0; n_cnt = 0;
            end else if (data_valid) begin
               e_rdy = 1; n_word = data; n_sh = 0; n_dir = m_lsb; n_st = 1;
            end
         end
      endcase
      exp_v = {e_rdy, e_sdo, e_oe, e_clk, e_done, e_und};
   endtask

   task automatic model_commit();
      m_st = n_st; m_cnt = n_cnt; m_tgt = n_tgt; m_L = n_L; m_sh = n_sh;
      m_lsb = n_lsb; m_dir = n_dir; m_word = n_word;
   endtask

   // Called at a falling edge; drives one cycle, samples mid-cycle, returns at the next falling edge.
   task automatic tick(input logic e, input logic ed, input logic v, input logic u,
                       input logic [1:0] md, input logic ls, input logic [CW-1:0] ci,
                       input logic [DW-1:0] d);
      en = e; tx_edge = ed; data_valid = v; counter_in_upd = u;
      mode_in = md; lsb_first_in = ls; counter_in = ci; data = d;
      #1;
      model_eval();
      act_v = dut_v;
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      en = 1; data_valid = 1; tx_edge = 1; #1;
      checks++;
      if (dut_v !== 12'h000) begin errors++; $display("FAIL reset_hold act=%h exp=000", dut_v); end
      @(negedge clk); rstn = 1; model_reset();
      tick(1, 0, 1, 0, 0, 0, 0, $urandom);
      for (int i = 0; i < 4; i++) begin
         tick(1, 1, 0, 0, 0, 0, 0, 0);
         checks++;
         if (act_v !== exp_v) begin errors++; $display("FAIL reset_pre act=%h exp=%h", act_v, exp_v); end
      end
      #2 rstn = 0; #1;
      checks++;
      if (dut_v !== 12'h000) begin errors++; $display("FAIL reset_mid act=%h exp=000", dut_v); end
      model_reset();
      @(negedge clk); rstn = 1;
      tick(1, 0, 1, 0, 0, 0, 0, $urandom);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1, 1, 0, 0, 0, 0, 0, 0);
         n++;
         checks++;
         if (act_v !== exp_v) begin errors++; $display("FAIL reset_tgt_seq act=%h exp=%h", act_v, exp_v); end
         if (act_v[1]) break;
      end
      checks++;
      if (n !== 32) begin errors++; $display("FAIL reset_target shifts=%0d exp=32", n); end
   endtask

   task automatic test_single_msb();
      logic [31:0] pat;
      pat = 32'hA5A5_0F0F;
      tick(0, 0, 0, 1, 2'b00, 0, 16'd32, 0);
      tick(1, 0, 1, 0, 0, 0, 0, pat);
      for (int i = 0; i < 32; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            tick(1, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL single_hold act=%h exp=%h", act_v, exp_v); end
         end
         tick(1, 1, 0, 0, 0, 0, 0, 0);
         checks++;
         if (act_v !== exp_v) begin errors++; $display("FAIL single_model i=%0d act=%h exp=%h", i, act_v, exp_v); end
         checks++;
         if ({act_v[7], act_v[2], act_v[1]} !== {pat[31-i], i != 31, i == 31}) begin
            errors++; $display("FAIL single_bit i=%0d sdo0/clken/done=%b exp=%b%b%b",
                               i, {act_v[7], act_v[2], act_v[1]}, pat[31-i], i != 31, i == 31);
         end
      end
   endtask

   task automatic test_quad_lsb();
      logic [3:0] nib [16] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1,
                               4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9};
      tick(0, 0, 0, 1, 2'b10, 1, 16'd64, 0);
      tick(1, 0, 1, 0, 0, 0, 0, 32'h1234_5678);
      for (int i = 0; i < 16; i++) begin
         tick(1, 1, i == 7, 0, 0, 0, 0, 32'h9ABC_DEF0);
         checks++;
         if (act_v !== exp_v) begin errors++; $display("FAIL quad_model i=%0d act=%h exp=%h", i, act_v, exp_v); end
         checks++;
         if ({act_v[10:7], act_v[11], act_v[1]} !== {nib[i], i == 7, i == 15}) begin
            errors++; $display("FAIL quad_nib i=%0d sdo/rdy/done=%h exp=%h", i,
                               {act_v[10:7], act_v[11], act_v[1]}, {nib[i], i == 7, i == 15});
         end
      end
   endtask

   task automatic test_dual_underrun();
      int n;
      logic ls;
      ls = 1'($urandom);
      tick(0, 0, 0, 1, 2'b01, ls, 16'd63, 0);
      tick(1, 0, 1, 0, 0, 0, 0, $urandom);
      for (int i = 0; i < 16; i++) begin
         tick(1, 1, 0, 0, 0, 0, 0, 0);
         checks++;
         if (act_v !== exp_v) begin errors++; $display("FAIL dual_model i=%0d act=%h exp=%h", i, act_v, exp_v); end
      end
      checks++;
      if ({act_v[2], act_v[0]} !== 2'b01) begin errors++; $display("FAIL dual_underrun clken/und=%b exp=01", {act_v[2], act_v[0]}); end
      for (int i = 0; i < 3; i++) begin
         tick(1, 1'($urandom), 0, 0, 0, 0, 0, 0);
         checks++;
         if (act_v !== exp_v || act_v[2] !== 1'b0) begin errors++; $display("FAIL dual_stall act=%h exp=%h", act_v, exp_v); end
      end
      tick(1, 0, 1, 0, 0, 0, 0, $urandom);
      checks++;
      if (act_v !== exp_v || act_v[11] !== 1'b1) begin errors++; $display("FAIL dual_resume act=%h exp=%h", act_v, exp_v); end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1, 1, 0, 0, 0, 0, 0, 0);
         n++;
         checks++;
         if (act_v !== exp_v) begin errors++; $display("FAIL dual_tail act=%h exp=%h", act_v, exp_v); end
         if (act_v[1]) break;
      end
      checks++;
      if (n !== 16) begin errors++; $display("FAIL dual_resume_len shifts=%0d exp=16", n); end
   endtask

   task automatic test_back_to_back();
      for (int it = 0; it < 6; it++) begin
         logic [1:0] md;
         int cin, tgt, edges, dones;
         logic ed;
         md = 2'($urandom_range(0, 3));
         cin = $urandom_range(0, 80);
         tgt = exp_target(cin, mlanes(md));
         tick(0, 0, 0, 1, md, 1'($urandom), CW'(cin), 0);
         tick(1, 0, 1, 0, 0, 0, 0, $urandom);
         edges = 0; dones = 0;
         for (int c = 0; c < 600 && dones < 2; c++) begin
            ed = ($urandom_range(0, 3) != 0);
            tick(1, ed, 1, 0, 0, 0, 0, $urandom);
            if (ed) edges++;
            checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL b2b_model it=%0d act=%h exp=%h", it, act_v, exp_v); end
            if (act_v[1]) begin
               dones++;
               checks++;
               if ({act_v[11], act_v[2], edges} !== {2'b11, tgt}) begin
                  errors++; $display("FAIL b2b_done it=%0d rdy/clken=%b shifts=%0d exp=11 %0d",
                                     it, {act_v[11], act_v[2]}, edges, tgt);
               end
               edges = 0;
            end
         end
         checks++;
         if (dones !== 2) begin errors++; $display("FAIL b2b_timeout it=%0d dones=%0d exp=2", it, dones); end
         tick(0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic test_abort_upd();
      int n;
      tick(0, 0, 0, 1, 2'b00, 0, 16'd32, 0);
      tick(1, 0, 1, 0, 0, 0, 0, $urandom);
      for (int i = 0; i < 5; i++) begin
         tick(1, 1, 0, i == 2, 2'b10, 1, 16'd8, 0);
         checks++;
         if (act_v !== exp_v) begin errors++; $display("FAIL abort_pre act=%h exp=%h", act_v, exp_v); end
      end
      tick(0, 1, 1, 0, 0, 0, 0, $urandom);
      checks++;
      if (act_v !== exp_v || {act_v[11], act_v[1]} !== 2'b00) begin errors++; $display("FAIL abort_cycle act=%h exp=%h", act_v, exp_v); end
      tick(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (act_v !== exp_v || act_v[6:2] !== 5'b0) begin errors++; $display("FAIL abort_idle act=%h exp=%h", act_v, exp_v); end
      tick(1, 0, 1, 0, 0, 0, 0, $urandom);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1, 1, 0, 0, 0, 0, 0, 0);
         n++;
         checks++;
         if (act_v !== exp_v) begin errors++; $display("FAIL abort_rerun act=%h exp=%h", act_v, exp_v); end
         if (act_v[1]) break;
      end
      checks++;
      if (n !== 32) begin errors++; $display("FAIL upd_ignored shifts=%0d exp=32", n); end
      tick(0, 0, 0, 1, 2'($urandom_range(0, 3)), 1'($urandom), 16'd0, 0);
      tick(1, 0, 1, 0, 0, 0, 0, $urandom);
      tick(1, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (act_v !== exp_v || act_v[1] !== 1'b1) begin errors++; $display("FAIL zero_len act=%h exp=%h", act_v, exp_v); end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_single_msb();
      test_quad_lsb();
      test_dual_underrun();
      test_back_to_back();
      test_abort_upd();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master_tx_mw.md
Name: spi_master_tx_mw

Overview:
Parametrised SPI master transmit shifter for single, dual and quad lanes, with MSB- or LSB-first ordering.
- Takes words of DATA_W bits from a valid/ready source and shifts them onto 1, 2 or 4 SDO lanes on each tx_edge strobe.
- The clock generator supplies tx_edge and consumes clk_en_o.
- Unlike the earlier fixed-32-bit block, it adds:
  - a STALL state on source underrun, which resumes without losing the bit position;
  - per-lane output enables;
  - transfer lengths that are not a multiple of the lane count.

Parameters:
DATA_W, 32, word width in bits; legal values are multiples of 4 that are ≥ 8.
CNT_W, 16, width of the transfer bit-length counter.
MAX_LANES, 4, number of physical SDO lanes; legal values are 1, 2 and 4.

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock, reset asynchronous and active-low
en  in  1  transfer enable; deassertion aborts the transfer
tx_edge  in  1  one-cycle shift strobe from the SPI clock generator
mode_in  in  2  lane mode: 00 single, 01 dual, 10 quad, 11 reserved (treated as single)
lsb_first_in  in  1  bit order; 0 = MSB first
counter_in  in  CNT_W  transfer length in bits
counter_in_upd  in  1  latches counter_in, mode_in and lsb_first_in
data  in  DATA_W  transmit word
data_valid  in  1  source valid
data_ready  out  1  word accepted this cycle (combinational)
sdo  out  MAX_LANES  serial data lanes
sdo_oe  out  MAX_LANES  per-lane output enable
clk_en_o  out  1  request the SPI clock to run (combinational)
tx_done  out  1  one-cycle pulse on the final shift of the transfer
underrun  out  1  one-cycle pulse on entry to STALL

Behaviour:
- Reset values:
  - state = IDLE; counter = 0; shift register = 0.
  - mode = single; lsb_first = 0.
  - target = DATA_W shifts.
  - All outputs are 0.
- L = lanes of the latched mode. A mode that needs more lanes than MAX_LANES is latched as single.
- Configuration latch:
  - Accepted only in IDLE; counter_in_upd is ignored in TRANSMIT and STALL.
  - Latched target = ceil(counter_in / L), computed as (counter_in + L − 1) >> log2(L).
  - counter_in = 0 is latched as target 1.
- Words and shifts:
  - Shifts per word W = DATA_W / L.
  - A word boundary occurs when (counter + 1) mod W == 0 on a tx_edge.
  - Final shift: counter == target − 1 and tx_edge.
- Lane mapping:
  - MSB first: sdo[k] = shreg[DATA_W − L + k] for k < L; each shift is shreg << L.
  - LSB first: sdo[k] = shreg[k]; each shift is shreg >> L.
  - Lanes ≥ L are driven 0.
- sdo_oe[k] = 1 when state ≠ IDLE and k < L.
- IDLE:
  - clk_en_o = 0.
  - If en && data_valid: data_ready = 1, load shreg = data, counter = 0, go to TRANSMIT.
- TRANSMIT:
  - clk_en_o = 1 while in TRANSMIT, except in the cycles noted below where it drops to 0.
  - A cycle with no tx_edge holds all state.
  - On tx_edge: counter + 1 and shift.
  - If the shift is the final shift:
    - tx_done = 1 and counter = 0.
    - If en && data_valid: load the next word with data_ready = 1 and stay in TRANSMIT (back-to-back transfer).
    - Otherwise: clk_en_o = 0 that cycle and go to IDLE.
  - Else if the shift is a word boundary:
    - If data_valid: load the word with data_ready = 1.
    - Otherwise: clk_en_o = 0, underrun = 1, go to STALL, keep the counter.
- STALL:
  - clk_en_o = 0; tx_edge is ignored.
  - If data_valid: data_ready = 1, load the word, return to TRANSMIT with the counter unchanged.
- Abort: en = 0 in TRANSMIT or STALL forces IDLE on the next clk.
  - counter is cleared; no tx_done or data_ready is produced that cycle.
  - The latched config is kept.
- Simultaneous events:
  - A final shift that is also a word boundary is handled as a final shift; the word-boundary rule does not apply.
  - An abort outranks tx_edge in the same cycle.
- Reset mid-operation returns immediately to reset values; there is no partial tx_done.
- Arithmetic: counter and target are CNT_W bits; the counter never exceeds target − 1.

Decomposition:
- Package spi_tx_pkg holds:
  - the lane-mode enum (SPI_SINGLE, SPI_DUAL, SPI_QUAD);
  - the state enum (IDLE, TRANSMIT, STALL);
  - a function for lanes(mode) and a function for its log2.
- One combinational sub-module, spi_tx_lane_sel: shreg, L and lsb_first in → sdo and sdo_oe out.

Test Plan:
- Reset: rstn low mid-TRANSMIT → sdo = 0, sdo_oe = 0, clk_en_o = 0, tx_done = 0 immediately. After release, state is IDLE and target = 32.
- Single, MSB first, counter_in = 32, data = 0xA5A5_0F0F → sdo[0] emits 1,0,1,0,0,1,0,1,… over 32 tx_edges. tx_done pulses on edge 32; clk_en_o falls the same cycle.
- Quad, LSB first, counter_in = 64, two words 0x1234_5678 and 0x9ABC_DEF0 → sdo[3:0] = 8,7,6,5,4,3,2,1 then 0,F,E,D,C,B,A,9.
  - data_ready pulses at the edge-8 boundary; tx_done pulses on edge 16.
- Dual, counter_in = 63 → target 32 shifts. Underrun at the edge-16 boundary → underrun pulse and STALL with clk_en_o = 0. Supplying data 3 cycles later resumes at counter 16; tx_done on shift 32.
- Back-to-back: en = 1 and data_valid = 1 at tx_done → the new word loads the same cycle, clk_en_o stays 1, the counter restarts at 0.
- Abort and ignored update: en dropped after 5 shifts → IDLE next clk, no tx_done. counter_in_upd pulsed during TRANSMIT → target unchanged.
